rvv_backend_decode_ctrl: RTL and testbench

Sequential uop-splitting controller between the command queue (CQ) and the decode unit. It tracks how many uops of the current instruction have already been issued and how many to issue this cycle, given the free space in the Uops Queue (UQ). It also decides when the instruction is popped from the CQ. It is parametrised in uops-per-cycle and maximum uops-per-instruction, and handles flush, illegal-instruction drop and back-pressure.

---
 rtl/rvv_backend_decode_ctrl_pkg.sv | 17 +
 rtl/rvv_backend_decode_emit_calc.sv | 27 ++
 rtl/rvv_backend_decode_ctrl.sv | 59 +++++
 tb/tb_rvv_backend_decode_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/rvv_backend_decode_ctrl_pkg.sv
// rvv_backend_decode_ctrl_pkg: shared sizing and control bundle for the decode stage
`ifndef NUM_DE_UOP
`define NUM_DE_UOP 4
`endif
`ifndef UOP_INDEX_WIDTH
`define UOP_INDEX_WIDTH 3
`endif
package rvv_backend_decode_ctrl_pkg;
  localparam int NUM_DE_UOP      = `NUM_DE_UOP;
  localparam int UOP_INDEX_WIDTH = `UOP_INDEX_WIDTH;
  localparam int UQ_FREE_WIDTH   = 4;
  typedef struct packed {
    logic [UOP_INDEX_WIDTH-1:0] index;
    logic [NUM_DE_UOP-1:0]      push;
    logic                       pop;
  } DECODE_CTRL_t;
endpackage

// File: rtl/rvv_backend_decode_emit_calc.sv
// rvv_backend_decode_emit_calc: emit = min(remain, NUM_DE_UOP, uq_free_cnt) and its thermometer mask
import rvv_backend_decode_ctrl_pkg::*;
module rvv_backend_decode_emit_calc #(
  parameter int NUM_DE_UOP      = rvv_backend_decode_ctrl_pkg::NUM_DE_UOP,
  parameter int UOP_INDEX_WIDTH = rvv_backend_decode_ctrl_pkg::UOP_INDEX_WIDTH,
  parameter int UQ_FREE_WIDTH   = rvv_backend_decode_ctrl_pkg::UQ_FREE_WIDTH
) (
  input  logic [UOP_INDEX_WIDTH:0]   remain,
  input  logic [UQ_FREE_WIDTH-1:0]   uq_free_cnt,
  output logic [UOP_INDEX_WIDTH:0]   emit,
  output logic [NUM_DE_UOP-1:0]      mask
);
  localparam int WA = UQ_FREE_WIDTH > UOP_INDEX_WIDTH + 1 ? UQ_FREE_WIDTH : UOP_INDEX_WIDTH + 1;
  localparam int WN = $clog2(NUM_DE_UOP + 1);
  localparam int W  = WA > WN ? WA : WN;
  logic [W-1:0] r, f, n, m1, m2;
  assign r  = W'(remain);
  assign f  = W'(uq_free_cnt);
  assign n  = W'(NUM_DE_UOP);
  assign m1 = r < n ? r : n;
  assign m2 = m1 < f ? m1 : f;
  // m2 never exceeds remain, so the narrowing is lossless
  assign emit = m2[UOP_INDEX_WIDTH:0];
  for (genvar i = 0; i < NUM_DE_UOP; i++) begin : g_mask
    assign mask[i] = m2 > W'(i);
  end
endmodule

// File: rtl/rvv_backend_decode_ctrl.sv
// rvv_backend_decode_ctrl: splits CQ head instructions into per-cycle uop pushes toward the UQ
import rvv_backend_decode_ctrl_pkg::*;
module rvv_backend_decode_ctrl #(
  parameter int NUM_DE_UOP      = rvv_backend_decode_ctrl_pkg::NUM_DE_UOP,
  parameter int UOP_INDEX_WIDTH = rvv_backend_decode_ctrl_pkg::UOP_INDEX_WIDTH,
  parameter int UQ_FREE_WIDTH   = rvv_backend_decode_ctrl_pkg::UQ_FREE_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inst_valid_cq2de,
  input  logic                       inst_illegal,
  input  logic [UOP_INDEX_WIDTH:0]   inst_uop_num,
  input  logic [UQ_FREE_WIDTH-1:0]   uq_free_cnt,
  input  logic                       flush,
  output logic [UOP_INDEX_WIDTH-1:0] uop_index_remain,
  output logic [NUM_DE_UOP-1:0]      uop_push_de2uq,
  output logic                       pop_de2cq,
  output logic                       decode_err,
  output logic [7:0]                 illegal_cnt
);
  logic [UOP_INDEX_WIDTH-1:0] index_q, index_d;
  logic [UOP_INDEX_WIDTH:0]   remain, emit;
  logic [NUM_DE_UOP-1:0]      mask;
  logic                       legal, drop, done;
  assign remain = inst_uop_num - {1'b0, index_q};
  rvv_backend_decode_emit_calc #(
    .NUM_DE_UOP(NUM_DE_UOP), .UOP_INDEX_WIDTH(UOP_INDEX_WIDTH), .UQ_FREE_WIDTH(UQ_FREE_WIDTH)
  ) u_emit (.remain(remain), .uq_free_cnt(uq_free_cnt), .emit(emit), .mask(mask));
  always_comb begin
    legal            = inst_valid_cq2de && !inst_illegal && inst_uop_num != '0 && !flush;
    drop             = inst_valid_cq2de && (inst_illegal || inst_uop_num == '0) && !flush;
    done             = emit == remain;
    uop_push_de2uq   = (rst_n && legal) ? mask : '0;
    pop_de2cq        = rst_n && (drop || (legal && done));
    index_d          = (flush || drop || (legal && done)) ? '0 :
                       legal ? index_q + emit[UOP_INDEX_WIDTH-1:0] : index_q;
    uop_index_remain = index_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index_q     <= '0;
      decode_err  <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      index_q <= index_d;
      if (drop) begin
        decode_err  <= 1'b1;
        illegal_cnt <= illegal_cnt == 8'hff ? illegal_cnt : illegal_cnt + 8'd1;
      end
    end
  end
`ifdef ASSERT_ON
`ifndef RVV_FORBID
`define RVV_FORBID(clk, rst_n, cond, msg) assert property (@(posedge clk) disable iff (!rst_n) !(cond)) else $error(msg);
`endif
  `RVV_FORBID(clk, rst_n, index_q != '0 && !inst_valid_cq2de, "cq head dropped mid-split")
  `RVV_FORBID(clk, rst_n, index_q != '0 && inst_uop_num != $past(inst_uop_num), "cq head changed mid-split")
`endif
endmodule

// File: tb/tb_rvv_backend_decode_ctrl.sv
// tb_rvv_backend_decode_ctrl: directed checks of uop splitting, drops, flush and reset
module tb_rvv_backend_decode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, inst_valid_cq2de, inst_illegal, flush;
  logic [3:0] inst_uop_num, uq_free_cnt;
  logic [2:0] uop_index_remain;
  logic [3:0] uop_push_de2uq;
  logic       pop_de2cq, decode_err;
  logic [7:0] illegal_cnt;
  int checks = 0, fails = 0;
  rvv_backend_decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_valid_cq2de(inst_valid_cq2de), .inst_illegal(inst_illegal),
    .inst_uop_num(inst_uop_num), .uq_free_cnt(uq_free_cnt), .flush(flush),
    .uop_index_remain(uop_index_remain), .uop_push_de2uq(uop_push_de2uq), .pop_de2cq(pop_de2cq),
    .decode_err(decode_err), .illegal_cnt(illegal_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic ill, input logic [3:0] num, input logic [3:0] free);
    inst_valid_cq2de = v;
    inst_illegal     = ill;
    inst_uop_num     = num;
    uq_free_cnt      = free;
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    tick(); tick();
    checks++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL reset_index got %0d exp 0", uop_index_remain); end
    checks++; if (decode_err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b exp 0", decode_err); end
    checks++; if (illegal_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", illegal_cnt); end
    rst_n = 1'b1;
  endtask
  task automatic test_split8();
    drive(1'b1, 1'b0, 4'd8, 4'd8);
    checks++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL split8_c0_index got %0d exp 0", uop_index_remain); end
    checks++; if (uop_push_de2uq !== 4'b1111) begin fails++; $display("FAIL split8_c0_mask got %b exp 1111", uop_push_de2uq); end
    checks++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL split8_c0_pop got %b exp 0", pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd4) begin fails++; $display("FAIL split8_c1_index got %0d exp 4", uop_index_remain); end
    checks++; if (uop_push_de2uq !== 4'b1111) begin fails++; $display("FAIL split8_c1_mask got %b exp 1111", uop_push_de2uq); end
    checks++; if (pop_de2cq !== 1'b1) begin fails++; $display("FAIL split8_c1_pop got %b exp 1", pop_de2cq); end
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd8);
    checks++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL split8_c2_index got %0d exp 0", uop_index_remain); end
    checks++; if (uop_push_de2uq !== 4'b0000 || pop_de2cq !== 1'b0) begin fails++; $display("FAIL idle_outputs got mask %b pop %b exp 0000 0", uop_push_de2uq, pop_de2cq); end
  endtask
  task automatic test_backpressure();
    drive(1'b1, 1'b0, 4'd3, 4'd2);
    checks++; if (uop_push_de2uq !== 4'b0011 || pop_de2cq !== 1'b0) begin fails++; $display("FAIL bp_free2 got mask %b pop %b exp 0011 0", uop_push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd2) begin fails++; $display("FAIL bp_index2 got %0d exp 2", uop_index_remain); end
    drive(1'b1, 1'b0, 4'd3, 4'd0);
    checks++; if (uop_push_de2uq !== 4'b0000 || pop_de2cq !== 1'b0) begin fails++; $display("FAIL bp_free0 got mask %b pop %b exp 0000 0", uop_push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd2) begin fails++; $display("FAIL bp_stall_index got %0d exp 2", uop_index_remain); end
    drive(1'b1, 1'b0, 4'd3, 4'd5);
    checks++; if (uop_push_de2uq !== 4'b0001 || pop_de2cq !== 1'b1) begin fails++; $display("FAIL bp_free5 got mask %b pop %b exp 0001 1", uop_push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL bp_final_index got %0d exp 0", uop_index_remain); end
  endtask
  task automatic test_illegal();
    drive(1'b1, 1'b1, 4'd2, 4'd8);
    checks++; if (uop_push_de2uq !== 4'b0000 || pop_de2cq !== 1'b1) begin fails++; $display("FAIL ill_outputs got mask %b pop %b exp 0000 1", uop_push_de2uq, pop_de2cq); end
    tick();
    checks++; if (decode_err !== 1'b1 || illegal_cnt !== 8'd1) begin fails++; $display("FAIL ill_first got err %b cnt %0d exp 1 1", decode_err, illegal_cnt); end
    drive(1'b1, 1'b0, 4'd0, 4'd8);
    checks++; if (uop_push_de2uq !== 4'b0000 || pop_de2cq !== 1'b1) begin fails++; $display("FAIL ill_zero_num got mask %b pop %b exp 0000 1", uop_push_de2uq, pop_de2cq); end
    tick();
    checks++; if (illegal_cnt !== 8'd2) begin fails++; $display("FAIL ill_zero_cnt got %0d exp 2", illegal_cnt); end
    drive(1'b1, 1'b1, 4'd2, 4'd8);
    for (int i = 0; i < 252; i++) tick();
    checks++; if (illegal_cnt !== 8'd254) begin fails++; $display("FAIL ill_cnt254 got %0d exp 254", illegal_cnt); end
    for (int i = 0; i < 46; i++) tick();
    checks++; if (illegal_cnt !== 8'd255) begin fails++; $display("FAIL ill_saturate got %0d exp 255", illegal_cnt); end
  endtask
  task automatic test_illegal_mid_split();
    drive(1'b1, 1'b0, 4'd8, 4'd8);
    tick();
    drive(1'b1, 1'b1, 4'd8, 4'd8);
    checks++; if (uop_push_de2uq !== 4'b0000 || pop_de2cq !== 1'b1) begin fails++; $display("FAIL ill_split got mask %b pop %b exp 0000 1", uop_push_de2uq, pop_de2cq); end
    tick();
    checks++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL ill_split_index got %0d exp 0", uop_index_remain); end
  endtask
  task automatic test_flush();
    drive(1'b1, 1'b0, 4'd8, 4'd8);
    tick();
    checks++; if (uop_index_remain !== 3'd4) begin fails++; $display("FAIL flush_pre_index got %0d exp 4", uop_index_remain); end
    flush = 1'b1;
    #1;
    checks++; if (uop_push_de2uq !== 4'b0000 || pop_de2cq !== 1'b0) begin fails++; $display("FAIL flush_outputs got mask %b pop %b exp 0000 0", uop_push_de2uq, pop_de2cq); end
    tick();
    flush = 1'b0;
    checks++; if (uop_index_remain !== 3'd0) begin fails++; $display("FAIL flush_index got %0d exp 0", uop_index_remain); end
    checks++; if (decode_err !== 1'b1 || illegal_cnt !== 8'd255) begin fails++; $display("FAIL flush_sticky got err %b cnt %0d exp 1 255", decode_err, illegal_cnt); end
    drive(1'b1, 1'b1, 4'd2, 4'd8);
    flush = 1'b1;
    #1;
    checks++; if (pop_de2cq !== 1'b0) begin fails++; $display("FAIL flush_over_illegal got pop %b exp 0", pop_de2cq); end
    flush = 1'b0;
  endtask
  task automatic test_reset_mid_split();
    drive(1'b1, 1'b0, 4'd8, 4'd8);
    tick();
    checks++; if (uop_index_remain !== 3'd4) begin fails++; $display("FAIL rst_pre_index got %0d exp 4", uop_index_remain); end
    rst_n = 1'b0;
    #1;
    checks++; if (uop_push_de2uq !== 4'b0000 || pop_de2cq !== 1'b0) begin fails++; $display("FAIL rst_outputs got mask %b pop %b exp 0000 0", uop_push_de2uq, pop_de2cq); end
    tick();
    rst_n = 1'b1;
    checks++; if (uop_index_remain !== 3'd0 || decode_err !== 1'b0 || illegal_cnt !== 8'd0) begin fails++; $display("FAIL rst_state got idx %0d err %b cnt %0d exp 0 0 0", uop_index_remain, decode_err, illegal_cnt); end
  endtask
  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 4'd1, 4'd1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (uop_push_de2uq !== 4'b0001 || pop_de2cq !== 1'b1 || uop_index_remain !== 3'd0) begin fails++; $display("FAIL b2b_%0d got mask %b pop %b idx %0d exp 0001 1 0", i, uop_push_de2uq, pop_de2cq, uop_index_remain); end
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0);
  endtask
  initial begin
    test_reset();
    test_split8();
    test_backpressure();
    test_illegal();
    test_illegal_mid_split();
    test_flush();
    test_reset_mid_split();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
